// File: rtl/count_ones_seq.sv
// count_ones_seq
// Sequential population counter. A word is accepted from idle when
// data_ready is high, then examined one bit per clock (LSB first). Counting
// stops as soon as no set bits remain in the shift register, so latency is
// (index of highest set bit + 1), or one cycle for an all-zero word.
// In zeros mode the word is inverted on load, so the same ones-counting
// datapath yields the zero count.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   data         word to count, sampled only on acceptance
//   data_ready   four-phase request level
//   count_zeros  0 = count ones, 1 = count zeros (sampled on acceptance)
//   bit_count    result, valid while done is high
//   start        one-cycle pulse in the cycle after acceptance
//   busy         high while counting
//   done         high while the result is held
module count_ones_seq #(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  data,
    input  logic                   data_ready,
    input  logic                   count_zeros,
    output logic [COUNT_WIDTH-1:0] bit_count,
    output logic                   start,
    output logic                   busy,
    output logic                   done
);

    // One-hot state encoding; busy and done are taken straight from the
    // state flops so they carry no combinational path from the inputs.
    localparam int S_IDLE  = 0;
    localparam int S_COUNT = 1;
    localparam int S_DONE  = 2;

    localparam logic [2:0] ST_IDLE  = 3'b001;
    localparam logic [2:0] ST_COUNT = 3'b010;
    localparam logic [2:0] ST_DONE  = 3'b100;

    logic [2:0]             state_reg;
    logic [2:0]             state_next;
    logic [DATA_WIDTH-1:0]  shreg_reg;
    logic [COUNT_WIDTH-1:0] cnt_reg;
    logic                   start_reg;
    logic [DATA_WIDTH-1:0]  shreg_shifted;

    assign shreg_shifted = shreg_reg >> 1;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        if (state_reg[S_IDLE]) begin
            if (data_ready) begin
                state_next = ST_COUNT;
            end
        end else if (state_reg[S_COUNT]) begin
            // Finish once the bit about to be consumed is the last set one.
            if (shreg_shifted == '0) begin
                state_next = ST_DONE;
            end
        end else if (state_reg[S_DONE]) begin
            if (!data_ready) begin
                state_next = ST_IDLE;
            end
        end else begin
            state_next = ST_IDLE;
        end
    end

    // Output decode
    always_comb begin
        busy      = state_reg[S_COUNT];
        done      = state_reg[S_DONE];
        start     = start_reg;
        bit_count = cnt_reg;
    end

    // Datapath: shift register, counter and start pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg_reg <= '0;
            cnt_reg   <= '0;
            start_reg <= 1'b0;
        end else begin
            start_reg <= 1'b0;
            if (state_reg[S_IDLE] && data_ready) begin
                shreg_reg <= count_zeros ? ~data : data;
                cnt_reg   <= '0;
                start_reg <= 1'b1;
            end else if (state_reg[S_COUNT]) begin
                cnt_reg   <= cnt_reg + COUNT_WIDTH'(shreg_reg[0]);
                shreg_reg <= shreg_shifted;
            end
        end
    end

endmodule

// File: tb/tb_count_ones_seq.sv
// Directed bench for count_ones_seq: an 8-bit instance for the main cases and
// a 4-bit instance for the exhaustive sweep. Expected count and latency are
// pushed to a scoreboard queue when a request is driven and popped when the
// selected instance raises done.
module tb_count_ones_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       count_zeros = 1'b0;
    logic [7:0] data8 = '0;
    logic       dr8 = 1'b0;
    logic [3:0] bc8;
    logic       start8, busy8, done8;
    logic [3:0] data4 = '0;
    logic       dr4 = 1'b0;
    logic [2:0] bc4;
    logic       start4, busy4, done4;

    logic       cur_sel = 1'b0;
    logic [3:0] cur_bc;
    logic       cur_start, cur_busy, cur_done;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int cnt;
        int lat;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    count_ones_seq #(.DATA_WIDTH(8), .COUNT_WIDTH(4)) dut8 (
        .clk(clk), .reset(reset), .data(data8), .data_ready(dr8),
        .count_zeros(count_zeros), .bit_count(bc8), .start(start8),
        .busy(busy8), .done(done8)
    );

    count_ones_seq #(.DATA_WIDTH(4), .COUNT_WIDTH(3)) dut4 (
        .clk(clk), .reset(reset), .data(data4), .data_ready(dr4),
        .count_zeros(count_zeros), .bit_count(bc4), .start(start4),
        .busy(busy4), .done(done4)
    );

    always_comb begin
        cur_bc    = cur_sel ? {1'b0, bc4} : bc8;
        cur_start = cur_sel ? start4 : start8;
        cur_busy  = cur_sel ? busy4 : busy8;
        cur_done  = cur_sel ? done4 : done8;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // One full transaction on the selected instance.
    task automatic run(input bit sel, input logic [7:0] d, input bit cz,
                       input bit mutate, input int hold);
        int   w;
        logic [7:0] v;
        exp_t e;
        exp_t got;
        int   lat;
        bit   seen;
        w = sel ? 4 : 8;
        v = cz ? ~d : d;
        e.cnt = 0;
        e.lat = 1;
        for (int i = 0; i < w; i++) begin
            if (v[i]) begin
                e.cnt++;
                e.lat = i + 1;
            end
        end

        @(negedge clk);
        cur_sel = sel;
        count_zeros = cz;
        if (sel) begin
            data4 = d[3:0];
            dr4 = 1'b1;
        end else begin
            data8 = d;
            dr8 = 1'b1;
        end
        sb.push_back(e);

        @(posedge clk); #1;
        check("start_pulse", cur_start, 1);
        check("busy_at_e0", cur_busy, 1);
        check("cnt_cleared", cur_bc, 0);
        if (mutate) begin
            data8 = 8'h00;
            data4 = 4'h0;
            count_zeros = ~count_zeros;
        end

        lat = 0;
        seen = 0;
        while (lat < 20 && !seen) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) check("start_low_e1", cur_start, 0);
            if (cur_done) seen = 1;
        end
        check("done_seen", seen, 1);
        got = sb.pop_front();
        check("bit_count", cur_bc, got.cnt);
        check("latency", lat, got.lat);
        check("busy_excl", cur_busy, 0);

        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check("hold_done", cur_done, 1);
            check("hold_no_start", cur_start, 0);
            check("hold_count", cur_bc, got.cnt);
        end

        @(negedge clk);
        dr8 = 1'b0;
        dr4 = 1'b0;
        @(posedge clk); #1;
        check("done_fall", cur_done, 0);
        check("idle_busy", cur_busy, 0);
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_bc8", bc8, 0);
        check("rst_start8", start8, 0);
        check("rst_busy8", busy8, 0);
        check("rst_done8", done8, 0);
        check("rst_bc4", bc4, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Reset mid-count
        @(negedge clk);
        data8 = 8'hFF;
        count_zeros = 1'b0;
        dr8 = 1'b1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        dr8 = 1'b0;
        #1;
        check("abort_busy", busy8, 0);
        check("abort_done", done8, 0);
        check("abort_start", start8, 0);
        check("abort_bc", bc8, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_busy", busy8, 0);
        check("post_rst_done", done8, 0);
        check("post_rst_bc", bc8, 0);

        // Ones mode
        run(0, 8'hFF, 0, 0, 0);
        run(0, 8'h05, 0, 0, 0);
        run(0, 8'h00, 0, 0, 0);
        // Zeros mode
        run(0, 8'hF0, 1, 0, 0);
        run(0, 8'h00, 1, 0, 0);
        // Input isolation during count
        run(0, 8'h81, 0, 1, 0);
        // Handshake: hold request past done, then relaunch
        run(0, 8'h3C, 0, 0, 5);
        run(0, 8'hFF, 0, 0, 0);

        // Exhaustive 4-bit sweep in both modes
        for (int m = 0; m < 2; m++) begin
            for (int x = 0; x < 16; x++) begin
                logic [7:0] dv;
                dv = 8'(x);
                run(1, dv, m[0], 0, 0);
            end
        end

        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
